ram_readback_checker: RTL and testbench

RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

---
 rtl/ram_readback_checker_pkg.sv | 39 +++
 rtl/ram_readback_checker_if.sv | 22 ++
 rtl/ram_readback_checker_cmp.sv | 22 ++
 rtl/ram_readback_checker.sv | 104 ++++++++++
 tb/tb_ram_readback_checker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_readback_checker_pkg.sv
// Shared types for the RAM readback checker: CPU/RAM bus types and the SHA-256
// round-constant table that the RAM is expected to hold (reversed order).
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

package sha256_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    DONE = 2'b10
  } readback_state_t;

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/ram_readback_checker_if.sv
// CPU-side RAM bus: the checker drives requests through the cpu modport, the
// RAM (or a model of it) answers through the ram modport.
interface cpu_ram_if;
  import cpu_types_pkg::*;

  logic      memREN;
  logic      memWEN;
  word_t     memaddr;
  word_t     memstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport cpu (
    output memREN, memWEN, memaddr, memstore,
    input  ramload, ramstate
  );

  modport ram (
    input  memREN, memWEN, memaddr, memstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_readback_checker_cmp.sv
// Combinational compare of one RAM word against the expected constant for
// its index; word i is expected to hold SHA256_K[63-i].
module readback_cmp
  import cpu_types_pkg::*;
  import sha256_pkg::*;
(
  input  logic [6:0] idx,
  input  word_t      ramload,
  output logic       match
);

  word_t expected;

  always_comb begin
    expected = '0;
    if (idx < 7'd64)
      expected = SHA256_K[6'(7'd63 - idx)];
  end

  assign match = (ramload == expected);

endmodule

// File: rtl/ram_readback_checker.sv
// Reads NWORDS words from RAM and checks them against the reversed SHA-256
// constant table. Define READBACK_EARLY_STOP_EN to end a pass on the first mismatch.
module ram_readback_checker
  import cpu_types_pkg::*;
  import sha256_pkg::*;
#(
  parameter int          NWORDS    = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  cpu_ram_if.cpu     scif,
  output logic       busy,
  output logic       halt,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [5:0] first_err_idx,
  output logic       bus_err
);

`ifdef READBACK_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  localparam logic [6:0] LAST_IDX = 7'(NWORDS - 1);

  readback_state_t state;
  logic [6:0]      idx;
  logic            mem_ren;
  logic            match;

  readback_cmp u_cmp (
    .idx     (idx),
    .ramload (scif.ramload),
    .match   (match)
  );

  assign scif.memREN   = mem_ren;
  assign scif.memWEN   = 1'b0;
  assign scif.memstore = '0;
  assign scif.memaddr  = BASE_ADDR + {23'b0, idx, 2'b00};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      idx           <= '0;
      mem_ren       <= 1'b0;
      busy          <= 1'b0;
      halt          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= READ;
            idx           <= '0;
            mem_ren       <= 1'b1;
            busy          <= 1'b1;
            halt          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            bus_err       <= 1'b0;
          end
        end
        READ: begin
          if (scif.ramstate == ERROR) begin
            state   <= DONE;
            mem_ren <= 1'b0;
            busy    <= 1'b0;
            halt    <= 1'b1;
            pass    <= 1'b0;
            bus_err <= 1'b1;
          end else if (scif.ramstate == ACCESS) begin
            if (!match) begin
              if (err_count < 7'd64)
                err_count <= err_count + 7'd1;
              if (err_count == 7'd0)
                first_err_idx <= idx[5:0];
            end
            // idx parks on the last word rather than running past it
            if (idx == LAST_IDX || (EARLY_STOP && !match)) begin
              state   <= DONE;
              mem_ren <= 1'b0;
              busy    <= 1'b0;
              halt    <= 1'b1;
              pass    <= match && (err_count == 7'd0);
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench for ram_readback_checker: RAM model with configurable wait
// states, error injection and corrupted words; vector table plus reset sequences.
module tb_ram_readback_checker;
  import cpu_types_pkg::*;

`ifdef READBACK_EARLY_STOP_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    string       name;
    logic [63:0] cmask;
    int          busy_wait;
    int          err_word;
    bit          mid_start;
    int          exp_pass;
    int          exp_ec;
    int          exp_first;
    int          exp_be;
    int          exp_acc;
    int          exp_iss;
  } vec_t;

  logic       CLK, RST, start;
  logic       busy, halt, pass, bus_err;
  logic [6:0] err_count;
  logic [5:0] first_err_idx;

  cpu_ram_if scif ();

  ram_readback_checker #(.NWORDS(64), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .RST(RST), .start(start), .scif(scif),
    .busy(busy), .halt(halt), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .bus_err(bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model
  logic [31:0] ram_mem [0:63];
  int          busy_wait, err_word, wcnt;
  ramstate_t   rs;

  always_comb begin
    rs = FREE;
    if (scif.memREN) begin
      if (int'(scif.memaddr[7:2]) == err_word) rs = ERROR;
      else if (wcnt < busy_wait)               rs = BUSY;
      else                                     rs = ACCESS;
    end
  end
  assign scif.ramstate = rs;
  assign scif.ramload  = ram_mem[scif.memaddr[7:2]];

  always @(posedge CLK) begin
    if (!scif.memREN || rs == ACCESS) wcnt <= 0;
    else if (rs == BUSY)              wcnt <= wcnt + 1;
  end

  // bus monitor, per-pass counters reset whenever pass_id changes
  int          pass_id, mon_id, acc_cnt, iss_cnt, seq_err, unstable;
  logic [63:0] seen;
  bit          prev_busy;
  logic [31:0] prev_addr;

  initial mon_id = -1;
  always @(negedge CLK) begin
    if (pass_id != mon_id) begin
      mon_id = pass_id; acc_cnt = 0; iss_cnt = 0; seq_err = 0; unstable = 0;
      seen = '0; prev_busy = 0;
    end
    if (scif.memREN) begin
      if (!seen[scif.memaddr[7:2]]) begin
        seen[scif.memaddr[7:2]] = 1'b1;
        iss_cnt++;
      end
      if (prev_busy && scif.memaddr != prev_addr) unstable++;
      if (scif.ramstate == ACCESS) begin
        if (scif.memaddr != 32'(acc_cnt * 4)) seq_err++;
        acc_cnt++;
      end
    end
    prev_busy = scif.memREN && (scif.ramstate == BUSY);
    prev_addr = scif.memaddr;
  end

  int n_tests, n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [63:0] cmask);
    for (int i = 0; i < 64; i++)
      ram_mem[i] = cmask[i] ? 32'h0 : K[63-i];
  endtask

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  vec_t vecs [9];
  bit   done_ok;

  initial begin
    n_tests = 0; n_fail = 0; pass_id = 0;
    RST = 1'b1; start = 1'b0; busy_wait = 0; err_word = -1;
    load_mem('0);
    repeat (3) @(negedge CLK);
    check("rst.busy", int'(busy), 0);
    check("rst.halt", int'(halt), 0);
    check("rst.pass", int'(pass), 0);
    check("rst.err_count", int'(err_count), 0);
    check("rst.first_err_idx", int'(first_err_idx), 0);
    check("rst.bus_err", int'(bus_err), 0);
    check("rst.memREN", int'(scif.memREN), 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check("idle.busy", int'(busy), 0);
    check("idle.memREN", int'(scif.memREN), 0);

    //           name        cmask                   bw ew  mid pass ec        first be      acc        iss
    vecs[0] = '{"clean",     64'h0,                  0, -1, 0,  1,   0,        0,    0,      64,        64};
    vecs[1] = '{"c5_40",     64'h0000_0100_0000_0020, 0, -1, 0, 0,   E ? 1 : 2, 5,   0,      E ? 6 : 64, E ? 6 : 64};
    vecs[2] = '{"err10",     64'h0,                  0, 10, 0,  0,   0,        0,    1,      10,        11};
    vecs[3] = '{"busy3",     64'h0,                  3, -1, 1,  1,   0,        0,    0,      64,        64};
    vecs[4] = '{"c0",        64'h1,                  0, -1, 0,  0,   1,        0,    0,      E ? 1 : 64, E ? 1 : 64};
    vecs[5] = '{"c63",       64'h8000_0000_0000_0000, 0, -1, 0, 0,   1,        63,   0,      64,        64};
    vecs[6] = '{"err0",      64'h0,                  0, 0,  0,  0,   0,        0,    1,      0,         1};
    vecs[7] = '{"call",      '1,                     0, -1, 0,  0,   E ? 1 : 64, 0,  0,      E ? 1 : 64, E ? 1 : 64};
    vecs[8] = '{"c3_err10",  64'h8,                  0, 10, 0,  0,   1,        3,    E ? 0 : 1, E ? 4 : 10, E ? 4 : 11};

    foreach (vecs[n]) begin
      load_mem(vecs[n].cmask);
      busy_wait = vecs[n].busy_wait;
      err_word  = vecs[n].err_word;
      pass_id++;
      pulse_start();
      check({vecs[n].name, ".start_busy"}, int'(busy), 1);
      check({vecs[n].name, ".start_halt"}, int'(halt), 0);
      done_ok = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge CLK);
        start = (vecs[n].mid_start && cyc == 40) ? 1'b1 : 1'b0;
        if (halt) begin done_ok = 1; break; end
      end
      start = 1'b0;
      check({vecs[n].name, ".finished"}, int'(done_ok), 1);
      check({vecs[n].name, ".pass"}, int'(pass), vecs[n].exp_pass);
      check({vecs[n].name, ".err_count"}, int'(err_count), vecs[n].exp_ec);
      check({vecs[n].name, ".first_err_idx"}, int'(first_err_idx), vecs[n].exp_first);
      check({vecs[n].name, ".bus_err"}, int'(bus_err), vecs[n].exp_be);
      check({vecs[n].name, ".busy"}, int'(busy), 0);
      check({vecs[n].name, ".accesses"}, acc_cnt, vecs[n].exp_acc);
      check({vecs[n].name, ".words_issued"}, iss_cnt, vecs[n].exp_iss);
      check({vecs[n].name, ".addr_seq_err"}, seq_err, 0);
      check({vecs[n].name, ".addr_unstable"}, unstable, 0);
      repeat (3) @(negedge CLK);
      check({vecs[n].name, ".hold_memREN"}, int'(scif.memREN), 0);
      check({vecs[n].name, ".hold_halt"}, int'(halt), 1);
      check({vecs[n].name, ".memWEN"}, int'(scif.memWEN), 0);
      check({vecs[n].name, ".memstore"}, int'(scif.memstore != 32'h0), 0);
    end

    // reset in the middle of a pass, then a fresh pass from address 0
    busy_wait = 0; err_word = -1;
    load_mem(E ? 64'h0 : 64'h8);
    pass_id++;
    pulse_start();
    done_ok = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLK);
      if (acc_cnt >= 30) begin done_ok = 1; break; end
    end
    check("midrst.reached_idx30", int'(done_ok), 1);
    check("midrst.pre_busy", int'(busy), 1);
    check("midrst.pre_err_count", int'(err_count), E ? 0 : 1);
    #2 RST = 1'b1;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.memREN", int'(scif.memREN), 0);
    check("midrst.halt", int'(halt), 0);
    check("midrst.pass", int'(pass), 0);
    check("midrst.err_count", int'(err_count), 0);
    check("midrst.first_err_idx", int'(first_err_idx), 0);
    check("midrst.bus_err", int'(bus_err), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("postrst.idle_busy", int'(busy), 0);
    check("postrst.idle_memREN", int'(scif.memREN), 0);
    load_mem('0);
    pass_id++;
    pulse_start();
    check("postrst.first_addr", int'(scif.memaddr), 0);
    done_ok = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge CLK);
      if (halt) begin done_ok = 1; break; end
    end
    check("postrst.finished", int'(done_ok), 1);
    check("postrst.pass", int'(pass), 1);
    check("postrst.accesses", acc_cnt, 64);
    check("postrst.addr_seq_err", seq_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
